// File: rtl/fb_pkg.sv
//------------------------------------------------------------------------------
// Module   : fb_pkg
// Brief    : Frame-buffer geometry, field widths and fill-engine state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fb_pkg;

  localparam int FB_H_RES   = 320;
  localparam int FB_V_RES   = 240;
  localparam int FB_COLOR_W = 24;
  localparam int FB_ADDR_W  = 17;
  localparam int FB_X_W     = 9;
  localparam int FB_Y_W     = 8;
  localparam int FB_SUM_W   = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : fb_pkg

`default_nettype wire

// File: rtl/rect_fill_engine_if.sv
//------------------------------------------------------------------------------
// Module   : rect_fill_engine_if
// Brief    : Command handshake plus frame-buffer write port of the fill engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rect_fill_engine_if #(
  parameter int COLOR_W = fb_pkg::FB_COLOR_W
);

  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [fb_pkg::FB_X_W-1:0]    cmd_x;
  logic [fb_pkg::FB_Y_W-1:0]    cmd_y;
  logic [fb_pkg::FB_X_W-1:0]    cmd_w;
  logic [fb_pkg::FB_Y_W-1:0]    cmd_h;
  logic [COLOR_W-1:0]           cmd_color;
  logic                         mem_hold;
  logic [fb_pkg::FB_ADDR_W-1:0] frame_buf_mem_address;
  logic [COLOR_W-1:0]           frame_buf_mem_data;
  logic                         frame_buf_mem_wren;

  // Command source and buffer arbiter side
  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_hold,
    input  cmd_ready, frame_buf_mem_address, frame_buf_mem_data, frame_buf_mem_wren
  );

  // Fill engine side
  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_hold,
    output cmd_ready, frame_buf_mem_address, frame_buf_mem_data, frame_buf_mem_wren
  );

endinterface : rect_fill_engine_if

`default_nettype wire

// File: rtl/rect_clip.sv
//------------------------------------------------------------------------------
// Module   : rect_clip
// Brief    : Clips a rectangle to the frame buffer and flags empty commands.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rect_clip
  import fb_pkg::*;
#(
  parameter int H_RES = FB_H_RES,
  parameter int V_RES = FB_V_RES
) (
  input  logic [FB_X_W-1:0] x_i,
  input  logic [FB_Y_W-1:0] y_i,
  input  logic [FB_X_W-1:0] w_i,
  input  logic [FB_Y_W-1:0] h_i,
  output logic [FB_X_W-1:0] x_end_o,
  output logic [FB_Y_W-1:0] y_end_o,
  output logic              empty_o
);

  localparam logic [FB_SUM_W-1:0] c_h_lim = FB_SUM_W'(H_RES);
  localparam logic [FB_SUM_W-1:0] c_v_lim = FB_SUM_W'(V_RES);

  logic [FB_SUM_W-1:0] w_x_sum;
  logic [FB_SUM_W-1:0] w_y_sum;
  logic [FB_SUM_W-1:0] w_x_lim;
  logic [FB_SUM_W-1:0] w_y_lim;

  // Sums are one bit wider than the widest field so x+w never wraps
  assign w_x_sum = {1'b0, x_i} + {1'b0, w_i};
  assign w_y_sum = {2'b00, y_i} + {2'b00, h_i};

  assign w_x_lim = (w_x_sum > c_h_lim) ? c_h_lim : w_x_sum;
  assign w_y_lim = (w_y_sum > c_v_lim) ? c_v_lim : w_y_sum;

  assign x_end_o = FB_X_W'(w_x_lim - FB_SUM_W'(1));
  assign y_end_o = FB_Y_W'(w_y_lim - FB_SUM_W'(1));

  assign empty_o = (w_i == '0) || (h_i == '0) ||
                   ({1'b0, x_i} >= c_h_lim) || ({2'b00, y_i} >= c_v_lim);

endmodule : rect_clip

`default_nettype wire

// File: rtl/rect_fill_engine.sv
//------------------------------------------------------------------------------
// Module   : rect_fill_engine
// Brief    : Fills a clipped rectangle of the frame buffer, one pixel per cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rect_fill_engine
  import fb_pkg::*;
#(
  parameter int H_RES   = FB_H_RES,
  parameter int V_RES   = FB_V_RES,
  parameter int COLOR_W = FB_COLOR_W
) (
  input  logic              clk,
  input  logic              rst,
  rect_fill_engine_if.slave bus,
  output logic              busy,
  output logic              done
);

  localparam logic [FB_ADDR_W-1:0] c_h_step = FB_ADDR_W'(H_RES);

  state_t                 state_q, state_d;
  logic [FB_X_W-1:0]      x_q, x_d;
  logic [FB_Y_W-1:0]      y_q, y_d;
  logic [FB_X_W-1:0]      w_q, w_d;
  logic [FB_Y_W-1:0]      h_q, h_d;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic [FB_X_W-1:0]      x_end_q, x_end_d;
  logic [FB_Y_W-1:0]      y_end_q, y_end_d;
  logic [FB_X_W-1:0]      cur_x_q, cur_x_d;
  logic [FB_Y_W-1:0]      cur_y_q, cur_y_d;
  logic [FB_ADDR_W-1:0]   row_base_q, row_base_d;
  logic [FB_ADDR_W-1:0]   addr_q, addr_d;

  logic [FB_X_W-1:0]      w_x_end;
  logic [FB_Y_W-1:0]      w_y_end;
  logic                   w_empty;
  logic                   w_wren;
  logic [FB_ADDR_W-1:0]   w_row_base;
  logic [FB_ADDR_W-1:0]   w_next_row;

  rect_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_clip (
    .x_i     (x_q),
    .y_i     (y_q),
    .w_i     (w_q),
    .h_i     (h_q),
    .x_end_o (w_x_end),
    .y_end_o (w_y_end),
    .empty_o (w_empty)
  );

  // Constant-coefficient product, evaluated once per command; per-pixel
  // addresses are stepped with adders only
  assign w_row_base = FB_ADDR_W'(y_q) * c_h_step;
  assign w_next_row = row_base_q + c_h_step;

  assign w_wren                    = (state_q == ST_FILL) && !bus.mem_hold;
  assign bus.cmd_ready             = (state_q == ST_IDLE);
  assign bus.frame_buf_mem_wren    = w_wren;
  assign bus.frame_buf_mem_address = addr_q;
  assign bus.frame_buf_mem_data    = color_q;
  assign busy                      = (state_q != ST_IDLE);
  assign done                      = (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          color_d = bus.cmd_color;
          state_d = ST_CLIP;
        end
      end

      ST_CLIP: begin
        x_end_d    = w_x_end;
        y_end_d    = w_y_end;
        cur_x_d    = x_q;
        cur_y_d    = y_q;
        row_base_d = w_row_base;
        addr_d     = w_row_base + FB_ADDR_W'(x_q);
        state_d    = w_empty ? ST_DONE : ST_FILL;
      end

      ST_FILL: begin
        if (w_wren) begin
          if (cur_x_q == x_end_q) begin
            if (cur_y_q == y_end_q) begin
              state_d = ST_DONE;
            end else begin
              cur_x_d    = x_q;
              cur_y_d    = cur_y_q + FB_Y_W'(1);
              row_base_d = w_next_row;
              addr_d     = w_next_row + FB_ADDR_W'(x_q);
            end
          end else begin
            cur_x_d = cur_x_q + FB_X_W'(1);
            addr_d  = addr_q + FB_ADDR_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      x_end_q    <= '0;
      y_end_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      x_end_q    <= x_end_d;
      y_end_q    <= y_end_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
    end
  end

endmodule : rect_fill_engine

`default_nettype wire

// File: tb/tb_rect_fill_engine.sv
//------------------------------------------------------------------------------
// Module   : tb_rect_fill_engine
// Brief    : Directed self-checking bench for rect_fill_engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rect_fill_engine;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;

  always #5 clk = ~clk;

  rect_fill_engine_if #(.COLOR_W(24)) bus ();

  rect_fill_engine #(
    .H_RES   (320),
    .V_RES   (240),
    .COLOR_W (24)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int done_lbl = -1;
  int acc      = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_lbl[$];
  int exp_addr[$];
  int exp_off[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write and done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.frame_buf_mem_wren === 1'b1) begin
      wr_addr.push_back(int'(bus.frame_buf_mem_address));
      wr_data.push_back(int'(bus.frame_buf_mem_data));
      wr_lbl.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_lbl = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_data.delete();
    wr_lbl.delete();
  endtask

  task automatic send_cmd(input int x, input int y, input int w, input int h, input int color);
    @(negedge clk);
    acc           = cyc;
    bus.cmd_x     = 9'(x);
    bus.cmd_y     = 8'(y);
    bus.cmd_w     = 9'(w);
    bus.cmd_h     = 8'(h);
    bus.cmd_color = 24'(color);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({tag, " done seen"}, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic check_writes(input string tag, input int color);
    check({tag, " write count"}, wr_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), wr_addr[i], exp_addr[i]);
      check($sformatf("%s data[%0d]", tag, i), wr_data[i], color);
      check($sformatf("%s time[%0d]", tag, i), wr_lbl[i] - acc, exp_off[i]);
    end
  endtask

  int d0;

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    bus.mem_hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.cmd_ready), 32'd1);
    check("reset busy",  32'(busy), 32'd0);
    check("reset done",  32'(done), 32'd0);
    check("reset wren",  32'(bus.frame_buf_mem_wren), 32'd0);
    check("reset addr",  32'(bus.frame_buf_mem_address), 32'd0);
    check("reset data",  32'(bus.frame_buf_mem_data), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic 4x2 rectangle
    clear_mon();
    d0 = done_cnt;
    send_cmd(10, 5, 4, 2, 24'hFF0000);
    check("basic busy", 32'(busy), 32'd1);
    wait_done("basic", d0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{1610, 1611, 1612, 1613, 1930, 1931, 1932, 1933};
    exp_off  = '{2, 3, 4, 5, 6, 7, 8, 9};
    check_writes("basic", 24'hFF0000);
    check("basic done time", done_lbl - acc, 10);
    check("basic done count", done_cnt - d0, 1);
    check("basic ready after", 32'(bus.cmd_ready), 32'd1);

    // Clipped at bottom-right corner
    clear_mon();
    d0 = done_cnt;
    send_cmd(318, 238, 10, 10, 24'h00A5C3);
    wait_done("clip", d0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{76478, 76479, 76798, 76799};
    exp_off  = '{2, 3, 4, 5};
    check_writes("clip", 24'h00A5C3);
    check("clip done time", done_lbl - acc, 6);

    // Zero width
    clear_mon();
    d0 = done_cnt;
    send_cmd(10, 5, 0, 2, 24'h123456);
    wait_done("zero w", d0);
    check("zero w ready next", 32'(bus.cmd_ready), 32'd1);
    check("zero w ready time", cyc - acc, 3);
    check("zero w done time", done_lbl - acc, 2);
    check("zero w writes", wr_addr.size(), 0);

    // Left column beyond the frame
    clear_mon();
    d0 = done_cnt;
    send_cmd(400, 5, 4, 2, 24'h654321);
    wait_done("x off", d0);
    check("x off ready next", 32'(bus.cmd_ready), 32'd1);
    check("x off done time", done_lbl - acc, 2);
    check("x off writes", wr_addr.size(), 0);

    // Three-cycle stall on the third pixel
    clear_mon();
    d0 = done_cnt;
    send_cmd(10, 5, 4, 2, 24'hFF0000);
    repeat (3) @(posedge clk);
    #1 bus.mem_hold = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.mem_hold = 1'b0;
    wait_done("hold", d0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{1610, 1611, 1612, 1613, 1930, 1931, 1932, 1933};
    exp_off  = '{2, 3, 7, 8, 9, 10, 11, 12};
    check_writes("hold", 24'hFF0000);
    if (wr_lbl.size() == 8) check("hold fill span", wr_lbl[7] - wr_lbl[0] + 1, 11);
    else                    check("hold fill span", wr_lbl.size(), 8);
    check("hold done time", done_lbl - acc, 13);

    // Reset after the fifth write
    clear_mon();
    d0 = done_cnt;
    send_cmd(10, 5, 4, 2, 24'h0F0F0F);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort wren", 32'(bus.frame_buf_mem_wren), 32'd0);
    check("abort ready", 32'(bus.cmd_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort addr", 32'(bus.frame_buf_mem_address), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_addr = '{1610, 1611, 1612, 1613, 1930};
    exp_off  = '{2, 3, 4, 5, 6};
    check_writes("abort", 24'h0F0F0F);
    check("abort no done", done_cnt - d0, 0);
    check("abort ready after", 32'(bus.cmd_ready), 32'd1);

    clear_mon();
    d0 = done_cnt;
    send_cmd(0, 0, 3, 1, 24'h00FF00);
    wait_done("post reset", d0);
    repeat (2) @(posedge clk);
    #1;
    exp_addr = '{0, 1, 2};
    exp_off  = '{2, 3, 4};
    check_writes("post reset", 24'h00FF00);

    // Second command offered mid-fill must be dropped
    clear_mon();
    d0 = done_cnt;
    send_cmd(0, 1, 2, 2, 24'h0000FF);
    @(negedge clk);
    check("busy ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_x     = 9'd50;
    bus.cmd_y     = 8'd50;
    bus.cmd_w     = 9'd1;
    bus.cmd_h     = 8'd1;
    bus.cmd_color = 24'hABCDEF;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    wait_done("ignore", d0);
    repeat (6) @(posedge clk);
    #1;
    exp_addr = '{320, 321, 640, 641};
    exp_off  = '{2, 3, 4, 5};
    check_writes("ignore", 24'h0000FF);
    check("ignore done count", done_cnt - d0, 1);
    check("ignore idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_rect_fill_engine

`default_nettype wire

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 SHALL have parameter H_RES, default 320, frame buffer width in pixels.
REQ-002 SHALL have parameter V_RES, default 240, frame buffer height in pixels.
REQ-003 SHALL have parameter COLOR_W, default 24, pixel width in bits (8R/8G/8B).
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command present.
REQ-007 SHALL have port cmd_ready  output  1  engine accepts a command.
REQ-008 SHALL have port cmd_x  input  9  left column of the rectangle.
REQ-009 SHALL have port cmd_y  input  8  top row of the rectangle.
REQ-010 SHALL have port cmd_w  input  9  width in pixels.
REQ-011 SHALL have port cmd_h  input  8  height in pixels.
REQ-012 SHALL have port cmd_color  input  COLOR_W  fill colour.
REQ-013 SHALL have port mem_hold  input  1  write stall from the VGA-side buffer arbiter.
REQ-014 SHALL have port frame_buf_mem_address  output  17  write address, y*H_RES+x.
REQ-015 SHALL have port frame_buf_mem_data  output  COLOR_W  write data.
REQ-016 SHALL have port frame_buf_mem_wren  output  1  write strobe, one pixel per cycle.
REQ-017 SHALL have port busy  output  1  high when not in IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse when a command completes.

Function
REQ-019 SHALL implement states IDLE, CLIP, FILL, DONE; cmd_ready=1 only in IDLE.
REQ-020 SHALL accept a command on the edge where cmd_valid&cmd_ready, latch all cmd_* fields, and enter CLIP.
REQ-021 SHALL in CLIP compute x_end=min(x+w,H_RES)-1 and y_end=min(y+h,V_RES)-1 with 10-bit intermediate sums (no wrap-around), and load row base = y*H_RES.
REQ-022 SHALL go CLIP->DONE with zero writes if w==0, h==0, x>=H_RES or y>=V_RES; otherwise CLIP->FILL.
REQ-023 SHALL in FILL drive frame_buf_mem_wren = !mem_hold combinationally, with address and data taken from registers.
REQ-024 SHALL advance the pixel only on edges where wren=1: x++, address++; at x==x_end, x returns to the latched x, row base += H_RES, y++.
REQ-025 SHALL hold all counters and keep wren=0 while mem_hold=1; a hold may be of any length and occur on any pixel.
REQ-026 SHALL go FILL->DONE on the write edge of pixel (x_end,y_end); the first write occurs 2 cycles after acceptance.
REQ-027 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
REQ-028 SHALL ignore cmd_valid whenever cmd_ready=0; no command is queued.
REQ-029 SHALL compute addresses incrementally, without a run-time multiplier.

Reset
REQ-030 SHALL on rst force IDLE; cmd_ready=1; wren, busy and done =0; address, data and counters =0.
REQ-031 SHALL abort an in-progress fill on reset with no further writes; pixels already written stay in memory.

Structure
REQ-032 SHALL take H_RES, V_RES, address/colour widths and the state enum from shared package fb_pkg.
REQ-033 SHALL place the clip/empty-check arithmetic in one combinational sub-module, rect_clip.

Verification
REQ-034 Rect x=10,y=5,w=4,h=2,color=FF0000, no hold -> 8 writes on consecutive cycles to 1610-1613 then 1930-1933, data FF0000, done the cycle after the last write.
REQ-035 Clip x=318,y=238,w=10,h=10 -> writes only to 76478, 76479, 76798, 76799; done follows.
REQ-036 Zero size w=0 (and separately x=400) -> no wren, done 2 cycles after acceptance, cmd_ready high the next cycle.
REQ-037 mem_hold high for 3 cycles at the 3rd pixel of REQ-034 -> wren low for those 3 cycles, no pixel skipped or duplicated, total 11 cycles of FILL.
REQ-038 rst pulse after the 5th write of REQ-034 -> wren drops immediately, cmd_ready=1 after release, a new command executes correctly.
REQ-039 Second cmd_valid pulse during FILL -> ignored; exactly one done and only the first command's writes.
